// File: rtl/gpu_vram_arbiter_if.sv
// One requester's beat port into the VRAM arbiter.
interface gpu_vram_arbiter_if;
    // req is held with we/addr/wdata stable until gnt; a beat transfers in
    // every cycle where req & gnt. rvalid is a single-cycle pulse qualifying
    // rdata for a read this requester issued earlier; it has no back-pressure.
    logic        req;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/gpu_vram_arbiter.sv
// Arbitrates the single 16-bit VRAM port between scanout, draw and transfer engines.
// Optional beat/stall counters are enabled by defining VRAM_ARB_STATS_EN.
module gpu_vram_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    gpu_vram_arbiter_if.slave  disp,
    gpu_vram_arbiter_if.slave  draw,
    gpu_vram_arbiter_if.slave  xfer,
    output logic               vram_ce,
    output logic               vram_we,
    output logic [19:0]        vram_addr,
    output logic [15:0]        vram_wdata,
    input  logic [15:0]        vram_rdata,
    output logic [2:0]         dbg_state
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [31:0]        stat_disp,
    output logic [31:0]        stat_draw,
    output logic [31:0]        stat_xfer,
    output logic [31:0]        stat_stall
`endif
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OWN_DISP = 3'd1,
        OWN_DRAW = 3'd2,
        OWN_XFER = 3'd3,
        TURN     = 3'd4
    } state_t;

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t        state;
    logic          rr_ptr;      // 0 = DRAW next, 1 = XFER next
    logic [CW-1:0] burst_cnt;
    logic [1:0]    vram_own;    // 0 disp, 1 draw, 2 xfer
    logic [RD_LAT-1:0] rd_v;
    logic [1:0]    rd_own [RD_LAT];

    logic        beat, beat_we, own_req, oth_req;
    logic [1:0]  beat_own;
    logic [19:0] beat_addr;
    logic [15:0] beat_wdata;

    function automatic state_t pick(input logic d, input logic r, input logic x, input logic rr);
        if (d) return OWN_DISP;
        if (r && x) return rr ? OWN_XFER : OWN_DRAW;
        if (r) return OWN_DRAW;
        if (x) return OWN_XFER;
        return IDLE;
    endfunction

    assign disp.gnt = (state == OWN_DISP) & disp.req;
    assign draw.gnt = (state == OWN_DRAW) & draw.req;
    assign xfer.gnt = (state == OWN_XFER) & xfer.req;
    assign beat     = disp.gnt | draw.gnt | xfer.gnt;

    // Owner/other view used by the two round-robin states.
    assign own_req = (state == OWN_XFER) ? xfer.req : draw.req;
    assign oth_req = (state == OWN_XFER) ? draw.req : xfer.req;

    always_comb begin
        beat_we    = draw.we;
        beat_addr  = draw.addr;
        beat_wdata = draw.wdata;
        beat_own   = 2'd1;
        if (state == OWN_DISP) begin
            beat_we = disp.we; beat_addr = disp.addr; beat_wdata = disp.wdata; beat_own = 2'd0;
        end else if (state == OWN_XFER) begin
            beat_we = xfer.we; beat_addr = xfer.addr; beat_wdata = xfer.wdata; beat_own = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            burst_cnt  <= '0;
            vram_ce    <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_own   <= 2'd0;
        end else begin
            vram_ce <= beat;
            vram_we <= beat & beat_we;
            if (beat) begin
                vram_addr  <= beat_addr;
                vram_wdata <= beat_wdata;
                vram_own   <= beat_own;
            end
            case (state)
                IDLE, TURN: begin
                    state     <= pick(disp.req, draw.req, xfer.req, rr_ptr);
                    burst_cnt <= '0;
                end
                OWN_DISP: begin
                    if (!disp.req) state <= (draw.req | xfer.req) ? TURN : IDLE;
                end
                OWN_DRAW, OWN_XFER: begin
                    if (disp.req || (!own_req && oth_req) ||
                        (own_req && oth_req && burst_cnt == CNT_LAST)) begin
                        state  <= TURN;
                        rr_ptr <= (state == OWN_DRAW);
                    end else if (!own_req) begin
                        state  <= IDLE;
                        rr_ptr <= (state == OWN_DRAW);
                    end else begin
                        burst_cnt <= (burst_cnt == CNT_LAST) ? '0 : burst_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read tags ride alongside the VRAM latency so rvalid lands with vram_rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_v <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_own[i] <= 2'd0;
        end else begin
            rd_v[0]   <= vram_ce & ~vram_we;
            rd_own[0] <= vram_own;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i]   <= rd_v[i-1];
                rd_own[i] <= rd_own[i-1];
            end
        end
    end

    assign disp.rvalid = rd_v[RD_LAT-1] & (rd_own[RD_LAT-1] == 2'd0);
    assign draw.rvalid = rd_v[RD_LAT-1] & (rd_own[RD_LAT-1] == 2'd1);
    assign xfer.rvalid = rd_v[RD_LAT-1] & (rd_own[RD_LAT-1] == 2'd2);
    assign disp.rdata  = vram_rdata;
    assign draw.rdata  = vram_rdata;
    assign xfer.rdata  = vram_rdata;
    assign dbg_state   = state;

`ifdef VRAM_ARB_STATS_EN
    logic stall;
    assign stall = (disp.req & ~disp.gnt) | (draw.req & ~draw.gnt) | (xfer.req & ~xfer.gnt);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_disp  <= '0;
            stat_draw  <= '0;
            stat_xfer  <= '0;
            stat_stall <= '0;
        end else begin
            stat_disp  <= sat_inc(stat_disp, disp.gnt);
            stat_draw  <= sat_inc(stat_draw, draw.gnt);
            stat_xfer  <= sat_inc(stat_xfer, xfer.gnt);
            stat_stall <= sat_inc(stat_stall, stall);
        end
    end
`endif
endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Directed bench for gpu_vram_arbiter; stats checks compile in with VRAM_ARB_STATS_EN.
module tb_gpu_vram_arbiter;
    localparam int LAT = 4;
    localparam int MB  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gpu_vram_arbiter_if disp_if ();
    gpu_vram_arbiter_if draw_if ();
    gpu_vram_arbiter_if xfer_if ();

    logic        vram_ce, vram_we;
    logic [19:0] vram_addr;
    logic [15:0] vram_wdata, vram_rdata;
    logic [2:0]  dbg_state;
`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_disp, stat_draw, stat_xfer, stat_stall;
`endif

    gpu_vram_arbiter #(.MAX_BURST(MB), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .disp(disp_if.slave), .draw(draw_if.slave), .xfer(xfer_if.slave),
        .vram_ce(vram_ce), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .dbg_state(dbg_state)
`ifdef VRAM_ARB_STATS_EN
        , .stat_disp(stat_disp), .stat_draw(stat_draw),
        .stat_xfer(stat_xfer), .stat_stall(stat_stall)
`endif
    );

    // ---------------- VRAM model: data is a fixed function of address ----------------
    function automatic logic [15:0] mem_val(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    logic [LAT-1:0] m_v = '0;
    logic [19:0]    m_a [LAT];
    always @(posedge clk) begin
        m_v     <= {m_v[LAT-2:0], vram_ce & ~vram_we};
        m_a[0]  <= vram_addr;
        for (int i = 1; i < LAT; i++) m_a[i] <= m_a[i-1];
    end
    assign vram_rdata = m_v[LAT-1] ? mem_val(m_a[LAT-1]) : 16'hDEAD;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard: {cycle, owner onehot {disp,draw,xfer}, data} ----------------
    logic [50:0] exp_q [$];
    logic        mon_en = 1'b0;
    function automatic logic [50:0] mk(input int c, input logic [2:0] w, input logic [15:0] d);
        logic [31:0] cc;
        cc = c;
        return {cc, w, d};
    endfunction

    logic [2:0]  rv;
    logic [50:0] e;
    always @(negedge clk) begin
        if (mon_en) begin
            rv = {disp_if.rvalid, draw_if.rvalid, xfer_if.rvalid};
            if (rv != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("rv_stray", {29'd0, rv}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rv_cyc", cyc, e[50:19]);
                    check("rv_who", {29'd0, rv}, {29'd0, e[18:16]});
                    check("rv_data", rv[2] ? disp_if.rdata : (rv[1] ? draw_if.rdata : xfer_if.rdata), {16'd0, e[15:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        disp_if.req = 1'b0; draw_if.req = 1'b0; xfer_if.req = 1'b0;
        disp_if.we  = 1'b0; draw_if.we  = 1'b0; xfer_if.we  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        clear_reqs();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [2:0] gnts();
        return {disp_if.gnt, draw_if.gnt, xfer_if.gnt};
    endfunction

    function automatic logic [2:0] t2_exp(input int k);
        if (k == 0 || (k - 1) % (MB + 1) == MB) return 3'b000;
        return (((k - 1) / (MB + 1)) % 2 == 0) ? 3'b010 : 3'b001;
    endfunction

    logic [2:0] t3_tab [15] = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd4,
                                3'd4, 3'd4, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
    logic [2:0] t4_tab [8]  = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int c0;
    initial begin
        // reset with every requester asserting: nothing may be granted
        rst = 1'b0;
        disp_if.req = 1'b1; draw_if.req = 1'b1; xfer_if.req = 1'b1;
        disp_if.we = 1'b0; draw_if.we = 1'b0; xfer_if.we = 1'b0;
        disp_if.addr = 20'h12345; draw_if.addr = 20'h12345; xfer_if.addr = 20'h12345;
        disp_if.wdata = 16'h0; draw_if.wdata = 16'h0; xfer_if.wdata = 16'h0;
        repeat (3) tick();
        smp();
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_gnt", {29'd0, gnts()}, 32'd0);
        check("rst_ce", {31'd0, vram_ce}, 32'd0);
        check("rst_we", {31'd0, vram_we}, 32'd0);
        check("rst_addr", {12'd0, vram_addr}, 32'd0);
        check("rst_wdata", {16'd0, vram_wdata}, 32'd0);
        check("rst_rv", {29'd0, disp_if.rvalid, draw_if.rvalid, xfer_if.rvalid}, 32'd0);
        tick();
        clear_reqs();
        rst = 1'b1;
        mon_en = 1'b1;

        // single DRAW read from IDLE
        tick();
        c0 = cyc;
        draw_if.req = 1'b1; draw_if.we = 1'b0; draw_if.addr = 20'h00010;
        exp_q.push_back(mk(c0 + 2 + LAT, 3'b010, mem_val(20'h00010)));
        smp();
        check("t1_gnt_c0", {31'd0, draw_if.gnt}, 32'd0);
        tick(); smp();
        check("t1_gnt_c1", {31'd0, draw_if.gnt}, 32'd1);
        check("t1_state", {29'd0, dbg_state}, 32'd2);
        tick();
        draw_if.req = 1'b0;
        smp();
        check("t1_ce", {31'd0, vram_ce}, 32'd1);
        check("t1_addr", {12'd0, vram_addr}, 32'h00010);
        check("t1_we", {31'd0, vram_we}, 32'd0);
        repeat (LAT + 2) tick();
        check("t1_q_empty", exp_q.size(), 32'd0);

        // DRAW and XFER both streaming writes: 16 beats, TURN, 16 beats, ...
        do_reset();
        tick();
        draw_if.req = 1'b1; draw_if.we = 1'b1; draw_if.addr = 20'h20000; draw_if.wdata = 16'h1111;
        xfer_if.req = 1'b1; xfer_if.we = 1'b1; xfer_if.addr = 20'h30000; xfer_if.wdata = 16'h2222;
        for (int k = 0; k <= 52; k++) begin
            if (k > 0) tick();
            smp();
            check("t2_gnt", {29'd0, gnts()}, {29'd0, t2_exp(k)});
            if (k == MB + 1) begin
                check("t2_ce_last", {31'd0, vram_ce}, 32'd1);
                check("t2_addr_last", {12'd0, vram_addr}, 32'h20000);
            end
            if (k == MB + 2) check("t2_ce_turn", {31'd0, vram_ce}, 32'd0);
            if (k == MB + 3) begin
                check("t2_ce_x", {31'd0, vram_ce}, 32'd1);
                check("t2_we_x", {31'd0, vram_we}, 32'd1);
                check("t2_addr_x", {12'd0, vram_addr}, 32'h30000);
                check("t2_wdata_x", {16'd0, vram_wdata}, 32'h2222);
            end
        end
        clear_reqs();

        // DISP preempts DRAW during its 5th beat
        do_reset();
        tick();
        draw_if.req = 1'b1; draw_if.we = 1'b1; draw_if.addr = 20'h00400; draw_if.wdata = 16'h3333;
        disp_if.we = 1'b1; disp_if.addr = 20'h07000; disp_if.wdata = 16'h4444;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            if (k == 5) disp_if.req = 1'b1;
            if (k == 10) disp_if.req = 1'b0;
            smp();
            check("t3_gnt", {29'd0, gnts()}, {29'd0, t3_tab[k]});
            if (k == 6) begin
                check("t3_ce_b5", {31'd0, vram_ce}, 32'd1);
                check("t3_addr_b5", {12'd0, vram_addr}, 32'h00400);
            end
            if (k == 8) begin
                check("t3_addr_disp", {12'd0, vram_addr}, 32'h07000);
                check("t3_wdata_disp", {16'd0, vram_wdata}, 32'h4444);
            end
        end
        clear_reqs();

        // DRAW read, then XFER reads issued before the DRAW data returns
        do_reset();
        tick();
        c0 = cyc;
        draw_if.req = 1'b1; draw_if.we = 1'b0; draw_if.addr = 20'h0ABCD;
        xfer_if.req = 1'b1; xfer_if.we = 1'b0; xfer_if.addr = 20'h12340;
        exp_q.push_back(mk(c0 + 6,  3'b010, mem_val(20'h0ABCD)));
        exp_q.push_back(mk(c0 + 9,  3'b001, mem_val(20'h12340)));
        exp_q.push_back(mk(c0 + 10, 3'b001, mem_val(20'h12341)));
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            if (k == 2) draw_if.req = 1'b0;
            if (k == 5) xfer_if.addr = 20'h12341;
            if (k == 6) begin xfer_if.we = 1'b1; xfer_if.addr = 20'h12342; end
            if (k == 7) xfer_if.req = 1'b0;
            smp();
            if (k < 8) check("t4_gnt", {29'd0, gnts()}, {29'd0, t4_tab[k]});
        end
        check("t4_q_empty", exp_q.size(), 32'd0);
        clear_reqs();

        // reset while two reads are in flight: their data must be dropped
        do_reset();
        tick();
        draw_if.req = 1'b1; draw_if.we = 1'b0; draw_if.addr = 20'h00055;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) tick();
            if (k == 2) draw_if.addr = 20'h00056;
            if (k == 3) draw_if.req = 1'b0;
            if (k == 4) rst = 1'b0;
            if (k == 5) rst = 1'b1;
            smp();
            if (k == 3) check("t5_ce_pre", {31'd0, vram_ce}, 32'd1);
            if (k == 5) begin
                check("t5_state", {29'd0, dbg_state}, 32'd0);
                check("t5_ce", {31'd0, vram_ce}, 32'd0);
                check("t5_addr", {12'd0, vram_addr}, 32'd0);
            end
            if (k >= 5) check("t5_rv", {29'd0, disp_if.rvalid, draw_if.rvalid, xfer_if.rvalid}, 32'd0);
        end

`ifdef VRAM_ARB_STATS_EN
        // 10 DRAW beats, XFER waiting for 3 cycles in total
        do_reset();
        tick();
        draw_if.req = 1'b1; draw_if.we = 1'b1; draw_if.addr = 20'h00100;
        xfer_if.req = 1'b1; xfer_if.we = 1'b1; xfer_if.addr = 20'h00200;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) tick();
            if (k == 1) xfer_if.req = 1'b0;
            if (k == 9) xfer_if.req = 1'b1;
            if (k == 11) begin draw_if.req = 1'b0; xfer_if.req = 1'b0; end
            smp();
        end
        check("st_draw", stat_draw, 32'd10);
        check("st_stall", stat_stall, 32'd3);
        check("st_xfer", stat_xfer, 32'd0);
        check("st_disp", stat_disp, 32'd0);
        do_reset();
        smp();
        check("st_draw_rst", stat_draw, 32'd0);
        check("st_stall_rst", stat_stall, 32'd0);
`endif

        check("final_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
